// File: rtl/ram_16x4_if.sv
// ---------------------------------------------------------------------------
// ram_16x4_if
//   Bus bundle between the CPU data path and the 16x4 data memory.
//   Signals:
//     write_en  master->slave  1 = write dataIN to mem[addr] on this edge
//     addr      master->slave  word address for read and write
//     dataIN    master->slave  write data
//     dataOut   slave->master  registered read data
//   Modports:
//     master  CPU side (drives address/data/write enable)
//     slave   memory side (drives read data)
// ---------------------------------------------------------------------------
interface ram_16x4_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) ();
  logic              write_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataIN;
  logic [DATA_W-1:0] dataOut;

  modport master (output write_en, output addr, output dataIN, input dataOut);
  modport slave  (input write_en, input addr, input dataIN, output dataOut);
endinterface

// File: rtl/ram_16x4.sv
// ---------------------------------------------------------------------------
// ram_16x4
//   Single-port synchronous data memory of the 4-bit computer: 16 words x 4
//   bits, write qualified by write_en, registered write-first read.
//   Ports:
//     clk    in   system clock, all state changes on rising edge
//     rst_n  in   synchronous active-low reset; clears every word and dataOut
//                 in a single edge, write_en ignored during reset
//     bus    slave modport of ram_16x4_if (write_en, addr, dataIN, dataOut)
// ---------------------------------------------------------------------------
module ram_16x4 #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_16x4_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  // Storage is a register array rather than block RAM: every word must clear
  // in one reset edge, which a RAM primitive cannot do.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;

  // Per-word next state: only the addressed word takes dataIN.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      assign mem_d[gi] = (bus.write_en && (bus.addr == ADDR_W'(gi)))
                         ? bus.dataIN : mem_q[gi];
    end
  endgenerate

  // Write-first: a write to the read address forwards the new data. With a
  // single address port the write always targets the read address.
  always_comb begin
    dout_d = mem_q[bus.addr];
    if (bus.write_en) begin
      dout_d = bus.dataIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      dout_q <= dout_d;
    end
  end

  assign bus.dataOut = dout_q;
endmodule

// File: tb/tb_ram_16x4.sv
// ---------------------------------------------------------------------------
// tb_ram_16x4
//   Directed bench for ram_16x4. An abstract memory model (plain array plus
//   expected output word) is updated on every rising edge from the applied
//   inputs and compared against dataOut on every falling edge once a reset
//   has defined the contents. Literal expectations after each step pin the
//   model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_ram_16x4;
  logic clk;
  logic rst_n;

  ram_16x4_if #(.DATA_W(4), .ADDR_W(4)) bus_if ();

  ram_16x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Behavioural model
  logic [3:0] model_mem [16];
  logic [3:0] model_out;
  bit         model_valid;

  initial begin
    model_valid = 1'b0;
    model_out   = 4'bx;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      foreach (model_mem[i]) model_mem[i] = 4'h0;
      model_out   = 4'h0;
      model_valid = 1'b1;
    end else begin
      if (bus_if.write_en === 1'b1) model_mem[bus_if.addr] = bus_if.dataIN;
      model_out = model_mem[bus_if.addr];
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (bus_if.dataOut !== model_out) begin
        failures++;
        $display("FAIL model_cmp t=%0t addr=%0d got=%h expected=%h",
                 $time, bus_if.addr, bus_if.dataOut, model_out);
      end
    end
  end

  task automatic check_lit(input string name, input logic [3:0] exp);
    checks++;
    if (bus_if.dataOut !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, bus_if.dataOut, exp);
    end else begin
      $display("ok   %s dataOut=%h", name, bus_if.dataOut);
    end
  endtask

  // Apply one cycle of inputs, let one rising edge pass, return at the
  // following falling edge.
  task automatic cyc(input logic r, input logic w, input logic [3:0] a,
                     input logic [3:0] d);
    rst_n           = r;
    bus_if.write_en = w;
    bus_if.addr     = a;
    bus_if.dataIN   = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n           = 1'b0;
    bus_if.write_en = 1'b0;
    bus_if.addr     = 4'h0;
    bus_if.dataIN   = 4'h0;

    // 1. Reset for two edges, then every address reads 0
    cyc(1'b0, 1'b0, 4'h0, 4'h0);
    check_lit("reset_dout", 4'h0);
    cyc(1'b0, 1'b0, 4'h0, 4'h0);
    for (int a = 0; a < 16; a++) begin
      cyc(1'b1, 1'b0, 4'(a), 4'h0);
      check_lit($sformatf("reset_read_%0d", a), 4'h0);
    end

    // 2. Back-to-back writes, then reads
    cyc(1'b1, 1'b1, 4'h0, 4'h9); check_lit("wr_9_at_0", 4'h9);
    cyc(1'b1, 1'b1, 4'h1, 4'h5); check_lit("wr_5_at_1", 4'h5);
    cyc(1'b1, 1'b1, 4'h3, 4'h2); check_lit("wr_2_at_3", 4'h2);
    cyc(1'b1, 1'b0, 4'h1, 4'h0); check_lit("rd_1", 4'h5);
    cyc(1'b1, 1'b0, 4'h0, 4'h0); check_lit("rd_0", 4'h9);
    cyc(1'b1, 1'b0, 4'h3, 4'h0); check_lit("rd_3", 4'h2);

    // Hold: inputs glitch between edges, dataOut must not move
    bus_if.addr   = 4'h0;
    bus_if.dataIN = 4'hF;
    #2;
    check_lit("hold_between_edges", 4'h2);

    // 3. Read-during-write is write-first
    cyc(1'b1, 1'b1, 4'h4, 4'h7); check_lit("rdw_7_at_4", 4'h7);
    cyc(1'b1, 1'b0, 4'h4, 4'h0); check_lit("rd_4", 4'h7);

    // 4. Write disabled leaves mem[0]
    cyc(1'b1, 1'b0, 4'h0, 4'hF); check_lit("wr_dis_dout", 4'h9);
    cyc(1'b1, 1'b0, 4'h0, 4'h0); check_lit("wr_dis_rd_0", 4'h9);

    // 5. Boundary addresses
    cyc(1'b1, 1'b1, 4'hF, 4'hF); check_lit("wr_F_at_15", 4'hF);
    cyc(1'b1, 1'b1, 4'h0, 4'h1); check_lit("wr_1_at_0", 4'h1);
    cyc(1'b1, 1'b0, 4'hF, 4'h0); check_lit("rd_15", 4'hF);
    cyc(1'b1, 1'b0, 4'h0, 4'h0); check_lit("rd_0_new", 4'h1);
    cyc(1'b1, 1'b0, 4'h2, 4'h0); check_lit("rd_2_unwritten", 4'h0);

    // 6. Reset mid-run with a simultaneous write request
    cyc(1'b0, 1'b1, 4'h5, 4'hA); check_lit("rst_mid_dout", 4'h0);
    cyc(1'b1, 1'b0, 4'h5, 4'h0); check_lit("rst_mid_rd_5", 4'h0);
    cyc(1'b1, 1'b0, 4'h1, 4'h0); check_lit("rst_mid_rd_1", 4'h0);
    cyc(1'b1, 1'b0, 4'hF, 4'h0); check_lit("rst_mid_rd_15", 4'h0);
    cyc(1'b1, 1'b0, 4'h0, 4'h0); check_lit("rst_mid_rd_0", 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
